// File: rtl/dds_wave_meter.sv
// Gated frequency / amplitude meter for 8-bit sample streams (ADC or DDS loopback).
// Optional build macro WAVE_METER_AVG_EN: report a 4-gate running average of the crossing count.
module dds_wave_meter #(
    parameter int GATE_CYCLES = 24000,
    parameter int HYST        = 4,
    parameter int CNT_W       = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic [7:0]       sample_in,
    input  logic             sample_vld,
    output logic [CNT_W-1:0] freq_cnt,
    output logic [7:0]       vmax,
    output logic [7:0]       vmin,
    output logic [7:0]       vpp,
    output logic             meas_valid,
    output logic             no_signal
);

    localparam int GATE_W = (GATE_CYCLES > 1) ? $clog2(GATE_CYCLES) : 1;

    typedef enum logic [1:0] {IDLE, MEASURE, REPORT} state_t;

    state_t             state, state_nxt;
    logic [GATE_W-1:0]  gate_cnt;
    logic [CNT_W-1:0]   cross_cnt;
    logic [7:0]         run_max, run_min, thr;
    logic               any_vld, armed;

    logic               gate_last, report_go, start_gate;
    logic signed [9:0]  thr_lo, thr_hi, samp_s;
    logic [7:0]         max_nxt, min_nxt;
    logic [CNT_W-1:0]   cross_nxt;
    logic               any_nxt, armed_nxt;
    logic [7:0]         rep_max, rep_min, rep_pp;
    logic [CNT_W-1:0]   rep_raw, rep_freq;
    logic               rep_ns;
    logic [8:0]         mid_sum;
    logic [7:0]         thr_nxt;

    assign gate_last  = (gate_cnt == GATE_W'(GATE_CYCLES - 1));
    assign report_go  = (state == MEASURE) && (state_nxt == REPORT);
    assign start_gate = (state_nxt == MEASURE) && (state != MEASURE);

    // Dropping en inside a gate abandons the window, even on its final cycle.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (en) state_nxt = MEASURE;
            MEASURE: begin
                if (!en)            state_nxt = IDLE;
                else if (gate_last) state_nxt = REPORT;
            end
            REPORT:  state_nxt = en ? MEASURE : IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Thresholds widened to signed so thr-HYST < 0 and thr+HYST > 255 simply never trigger.
    assign thr_lo = $signed({2'b00, thr}) - $signed(10'(HYST));
    assign thr_hi = $signed({2'b00, thr}) + $signed(10'(HYST));
    assign samp_s = $signed({2'b00, sample_in});

    // Running statistics including the current sample, so the final gate cycle is counted.
    always_comb begin
        max_nxt   = run_max;
        min_nxt   = run_min;
        any_nxt   = any_vld;
        armed_nxt = armed;
        cross_nxt = cross_cnt;
        if (sample_vld) begin
            any_nxt = 1'b1;
            if (sample_in > run_max) max_nxt = sample_in;
            if (sample_in < run_min) min_nxt = sample_in;
            if (armed && (samp_s >= thr_hi)) begin
                armed_nxt = 1'b0;
                if (cross_cnt != '1) cross_nxt = cross_cnt + 1'b1;
            end else if (samp_s < thr_lo) begin
                armed_nxt = 1'b1;
            end
        end
    end

    always_comb begin
        rep_max = any_nxt ? max_nxt : 8'd0;
        rep_min = any_nxt ? min_nxt : 8'd0;
        rep_pp  = rep_max - rep_min;
        rep_raw = any_nxt ? cross_nxt : '0;
        rep_ns  = !any_nxt || (rep_raw == '0) || ({1'b0, rep_pp} <= 9'(2 * HYST));
        mid_sum = {1'b0, rep_max} + {1'b0, rep_min};
        thr_nxt = rep_ns ? 8'd128 : 8'(mid_sum >> 1);
    end

`ifdef WAVE_METER_AVG_EN
    logic [CNT_W-1:0] hist [4];
    logic [CNT_W+1:0] avg_sum;

    assign avg_sum  = {2'b00, rep_raw} + {2'b00, hist[0]} + {2'b00, hist[1]} + {2'b00, hist[2]};
    assign rep_freq = any_nxt ? CNT_W'(avg_sum >> 2) : '0;

    // History survives en toggling; only reset clears it.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < 4; i++) hist[i] <= '0;
        end else if (report_go) begin
            hist[0] <= rep_raw;
            hist[1] <= hist[0];
            hist[2] <= hist[1];
            hist[3] <= hist[2];
        end
    end
`else
    assign rep_freq = rep_raw;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            gate_cnt   <= '0;
            cross_cnt  <= '0;
            run_max    <= 8'd0;
            run_min    <= 8'd0;
            any_vld    <= 1'b0;
            armed      <= 1'b0;
            thr        <= 8'd128;
            freq_cnt   <= '0;
            vmax       <= 8'd0;
            vmin       <= 8'd0;
            vpp        <= 8'd0;
            meas_valid <= 1'b0;
            no_signal  <= 1'b1;
        end else begin
            state      <= state_nxt;
            meas_valid <= 1'b0;
            if (start_gate) begin
                gate_cnt  <= '0;
                cross_cnt <= '0;
                run_max   <= 8'd0;
                run_min   <= 8'd255;
                any_vld   <= 1'b0;
                armed     <= 1'b0;
            end else if (state == MEASURE) begin
                gate_cnt  <= gate_cnt + GATE_W'(1);
                cross_cnt <= cross_nxt;
                run_max   <= max_nxt;
                run_min   <= min_nxt;
                any_vld   <= any_nxt;
                armed     <= armed_nxt;
            end
            if (report_go) begin
                freq_cnt   <= rep_freq;
                vmax       <= rep_max;
                vmin       <= rep_min;
                vpp        <= rep_pp;
                no_signal  <= rep_ns;
                thr        <= thr_nxt;
                meas_valid <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_dds_wave_meter.sv
// Scoreboard bench for dds_wave_meter: directed gates push expected reports, a monitor pops them on meas_valid.
module tb_dds_wave_meter;

    localparam int GATE  = 1000;
    localparam int HYST  = 4;
    localparam int CNT_W = 16;

    logic             clk = 1'b0;
    logic             rst, en, sample_vld;
    logic [7:0]       sample_in;
    logic [CNT_W-1:0] freq_cnt;
    logic [7:0]       vmax, vmin, vpp;
    logic             meas_valid, no_signal;

    dds_wave_meter #(.GATE_CYCLES(GATE), .HYST(HYST), .CNT_W(CNT_W)) dut (
        .clk(clk), .rst(rst), .en(en), .sample_in(sample_in), .sample_vld(sample_vld),
        .freq_cnt(freq_cnt), .vmax(vmax), .vmin(vmin), .vpp(vpp),
        .meas_valid(meas_valid), .no_signal(no_signal)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int    f, mx, mn, pp, ns, at;
        string name;
    } exp_t;

    exp_t sb[$];
    exp_t last_exp;
    int   checks = 0;
    int   errors = 0;
    int   hist[4] = '{0, 0, 0, 0};

    task automatic checkOutput(input string name, input int act, input int req);
        checks++;
        if (act != req) begin
            errors++;
            $display("[TB] FAIL %s: got %0d, expected %0d", name, act, req);
        end
    endtask

    // Reported frequency: raw crossings, or the 4-gate average when that build option is on.
    function automatic int expF(input int raw, input bit any);
`ifdef WAVE_METER_AVG_EN
        int s;
        s = raw + hist[0] + hist[1] + hist[2];
        hist[3] = hist[2];
        hist[2] = hist[1];
        hist[1] = hist[0];
        hist[0] = raw;
        return any ? (s >> 2) : 0;
`else
        return any ? raw : 0;
`endif
    endfunction

    // Call right after the clock edge that starts the gate; report is due GATE cycles later.
    task automatic pushExp(input string name, input int raw, input bit any,
                           input int mx, input int mn, input int pp, input int ns);
        exp_t e;
        e.name = name;
        e.f = expF(raw, any);
        e.mx = mx;
        e.mn = mn;
        e.pp = pp;
        e.ns = ns;
        e.at = cyc + GATE;
        sb.push_back(e);
        last_exp = e;
    endtask

    // Square wave: first half of each period at lo, second half at hi; full gates add the report cycle.
    task automatic applyStimulus(input int lo, input int hi, input int period, input bit vld,
                                 input int n, input bit en_after);
        for (int k = 0; k < n; k++) begin
            sample_in  = ((k % period) < (period / 2)) ? 8'(lo) : 8'(hi);
            sample_vld = vld;
            @(posedge clk); #1;
        end
        if (n == GATE) begin
            en        = en_after;
            sample_in = 8'd0;
            @(posedge clk); #1;
        end
    endtask

    task automatic checkReset(input string tag);
        checkOutput({tag, "_freq"},  freq_cnt,   0);
        checkOutput({tag, "_vmax"},  vmax,       0);
        checkOutput({tag, "_vmin"},  vmin,       0);
        checkOutput({tag, "_vpp"},   vpp,        0);
        checkOutput({tag, "_nosig"}, no_signal,  1);
        checkOutput({tag, "_mv"},    meas_valid, 0);
    endtask

    always @(negedge clk) begin
        exp_t e;
        if (!rst && meas_valid) begin
            if (sb.size() == 0) begin
                checkOutput("unexpected_pulse", 1, 0);
            end else begin
                e = sb.pop_front();
                checkOutput({e.name, "_freq"},  freq_cnt,  e.f);
                checkOutput({e.name, "_vmax"},  vmax,      e.mx);
                checkOutput({e.name, "_vmin"},  vmin,      e.mn);
                checkOutput({e.name, "_vpp"},   vpp,       e.pp);
                checkOutput({e.name, "_nosig"}, no_signal, e.ns);
                checkOutput({e.name, "_cycle"}, cyc,       e.at);
            end
        end
    end

    initial begin
        #2000000;
        $display("[TB] FAIL watchdog: got timeout, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        rst = 1'b1; en = 1'b0; sample_in = 8'd0; sample_vld = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        checkReset("reset");
        rst = 1'b0;
        @(posedge clk); #1;

        en = 1'b1;
        @(posedge clk); #1;
        pushExp("sq0_255", 10, 1, 255, 0, 255, 0);
        applyStimulus(0, 255, 100, 1, GATE, 1);
        pushExp("sq100_200", 10, 1, 200, 100, 100, 0);
        applyStimulus(100, 200, 100, 1, GATE, 1);
        pushExp("thr150", 10, 1, 200, 140, 60, 0);
        applyStimulus(140, 200, 100, 1, GATE, 1);
        pushExp("const128", 0, 1, 128, 128, 0, 1);
        applyStimulus(128, 128, 100, 1, GATE, 1);
        pushExp("alt126_130", 0, 1, 130, 126, 4, 1);
        applyStimulus(126, 130, 2, 1, GATE, 1);
        pushExp("thr_back128", 10, 1, 200, 100, 100, 0);
        applyStimulus(100, 200, 100, 1, GATE, 1);
        pushExp("no_vld", 0, 0, 0, 0, 0, 1);
        applyStimulus(0, 255, 100, 0, GATE, 1);
        pushExp("after_novld", 10, 1, 255, 0, 255, 0);
        applyStimulus(0, 255, 100, 1, GATE, 1);

        applyStimulus(0, 255, 100, 1, 500, 1);
        en = 1'b0;
        @(posedge clk); #1;
        repeat (20) @(posedge clk);
        #1;
        checkOutput("hold_freq",  freq_cnt,   last_exp.f);
        checkOutput("hold_vmax",  vmax,       last_exp.mx);
        checkOutput("hold_vmin",  vmin,       last_exp.mn);
        checkOutput("hold_vpp",   vpp,        last_exp.pp);
        checkOutput("hold_nosig", no_signal,  last_exp.ns);
        checkOutput("hold_mv",    meas_valid, 0);

        en = 1'b1;
        @(posedge clk); #1;
        pushExp("rearm", 10, 1, 255, 0, 255, 0);
        applyStimulus(0, 255, 100, 1, GATE, 1);

        applyStimulus(0, 255, 100, 1, 300, 1);
        rst = 1'b1;
        @(posedge clk); #1;
        checkReset("midgate_rst");
        hist = '{0, 0, 0, 0};
        rst = 1'b0;
        @(posedge clk); #1;

        pushExp("avg1", 8, 1, 255, 0, 255, 0);
        applyStimulus(0, 255, 125, 1, GATE, 1);
        pushExp("avg2", 8, 1, 255, 0, 255, 0);
        applyStimulus(0, 255, 125, 1, GATE, 1);
        pushExp("avg3", 8, 1, 255, 0, 255, 0);
        applyStimulus(0, 255, 125, 1, GATE, 1);
        pushExp("avg4", 8, 1, 255, 0, 255, 0);
        applyStimulus(0, 255, 125, 1, GATE, 0);

        repeat (5) @(posedge clk);
        #1;
        checkOutput("scoreboard_drained", sb.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
